// File: rtl/job_fifo_pkg.sv
// rtl/job_fifo_pkg.sv - default sizing constants and job word type for job_fifo
package job_fifo_pkg;

  localparam int JOB_FIFO_DEPTH      = 8;
  localparam int JOB_FIFO_DATA_WIDTH = 128;
  localparam int JOB_FIFO_ADDR_WIDTH = 3;

  typedef logic [JOB_FIFO_DATA_WIDTH-1:0] job_word_t;

endpackage

// File: rtl/job_fifo_mem.sv
// rtl/job_fifo_mem.sv - job descriptor storage: one write port, one registered read port, no reset
module job_fifo_mem #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/job_fifo.sv
// rtl/job_fifo.sv - single-clock job descriptor FIFO with registered read data
// Optional JOB_FIFO_COUNT_EN adds count, overflow and underflow outputs.
module job_fifo
  import job_fifo_pkg::*;
#(
  parameter int DEPTH      = JOB_FIFO_DEPTH,
  parameter int DATA_WIDTH = JOB_FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = JOB_FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty
`ifdef JOB_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  rd_seen;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_seen <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        rd_seen <= 1'b1;
      end
    end
  end

  job_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (mem_rd_data)
  );

  // Storage has no reset, so read data reads as zero until the first accepted read.
  assign rd_data = rd_seen ? mem_rd_data : '0;

`ifdef JOB_FIFO_COUNT_EN
  assign count = wr_ptr - rd_ptr;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_job_fifo.sv
// tb/tb_job_fifo.sv - table vectors, corner sequences and random traffic against a queue model
module tb_job_fifo;
  import job_fifo_pkg::*;

  localparam int DEPTH = JOB_FIFO_DEPTH;
  localparam int DW    = JOB_FIFO_DATA_WIDTH;
  localparam int AW    = JOB_FIFO_ADDR_WIDTH;

  logic      clk = 1'b0;
  logic      rst_n = 1'b1;
  logic      wr_en = 1'b0;
  logic      rd_en = 1'b0;
  job_word_t wr_data = '0;
  job_word_t rd_data;
  logic      full;
  logic      empty;
`ifdef JOB_FIFO_COUNT_EN
  logic [AW:0] count;
  logic        overflow;
  logic        underflow;
`endif

  always #5 clk = ~clk;

  job_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty)
`ifdef JOB_FIFO_COUNT_EN
    ,
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  int        vectors = 0;
  int        miscompares = 0;
  job_word_t q[$];
  job_word_t exp_rd = '0;
  bit        exp_ovf = 1'b0;
  bit        exp_unf = 1'b0;

  typedef struct {
    bit        wr;
    bit        rd;
    job_word_t wd;
    bit        e_empty;
    bit        e_full;
    job_word_t e_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input job_word_t got, input job_word_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic model_check();
    check_bit("model empty", empty, q.size() == 0);
    check_bit("model full", full, q.size() == DEPTH);
    check("model rd_data", rd_data, exp_rd);
`ifdef JOB_FIFO_COUNT_EN
    check("model count", job_word_t'(count), job_word_t'(q.size()));
    check_bit("model overflow", overflow, exp_ovf);
    check_bit("model underflow", underflow, exp_unf);
`endif
  endtask

  task automatic step(input bit wr, input bit rd, input job_word_t d);
    bit was_full;
    bit was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    wr_en   = wr;
    rd_en   = rd;
    wr_data = d;
    @(posedge clk);
    #1;
    if (rd && !was_empty) exp_rd = q.pop_front();
    else if (rd) exp_unf = 1'b1;
    if (wr && !was_full) q.push_back(d);
    else if (wr) exp_ovf = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_check();
  endtask

  task automatic model_reset();
    q.delete();
    exp_rd  = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    model_check();
    rst_n = 1'b0;
  endtask

  initial begin
    job_word_t sim_exp[10];
    int pw;
    int pr;

    for (int i = 0; i < 8; i++) tbl.push_back('{1'b1, 1'b0, job_word_t'(i), 1'b0, (i == 7), '0});
    tbl.push_back('{1'b1, 1'b0, job_word_t'(16'hDEAD), 1'b0, 1'b1, '0});
    for (int i = 0; i < 8; i++) tbl.push_back('{1'b0, 1'b1, '0, (i == 7), 1'b0, job_word_t'(i)});
    tbl.push_back('{1'b0, 1'b1, '0, 1'b1, 1'b0, job_word_t'(7)});

    do_reset();
    check_bit("reset empty", empty, 1'b1);
    check_bit("reset full", full, 1'b0);
    check("reset rd_data", rd_data, '0);

    foreach (tbl[k]) begin
      step(tbl[k].wr, tbl[k].rd, tbl[k].wd);
      check_bit($sformatf("tbl%0d empty", k), empty, tbl[k].e_empty);
      check_bit($sformatf("tbl%0d full", k), full, tbl[k].e_full);
      check($sformatf("tbl%0d rd_data", k), rd_data, tbl[k].e_rd);
`ifdef JOB_FIFO_COUNT_EN
      if (k == 7) check("fill count", job_word_t'(count), job_word_t'(8));
      if (k == 8) check_bit("overflow set", overflow, 1'b1);
      if (k == 17) check_bit("underflow set", underflow, 1'b1);
`endif
    end

    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, job_word_t'(10 + i));
    for (int i = 0; i < 4; i++) sim_exp[i] = job_word_t'(10 + i);
    for (int i = 4; i < 10; i++) sim_exp[i] = job_word_t'(96 + i);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, job_word_t'(100 + i));
      check($sformatf("sim rd %0d", i), rd_data, sim_exp[i]);
      check_bit("sim not empty", empty, 1'b0);
      check_bit("sim not full", full, 1'b0);
`ifdef JOB_FIFO_COUNT_EN
      check("sim count", job_word_t'(count), job_word_t'(4));
`endif
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, job_word_t'(200 + i));
    check_bit("full before sim", full, 1'b1);
    step(1'b1, 1'b1, job_word_t'(300));
    check("sim at full rd", rd_data, job_word_t'(106));
    check_bit("sim at full drops write", full, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, '0);
    check("last drained", rd_data, job_word_t'(203));
    check_bit("drained empty", empty, 1'b1);
    step(1'b1, 1'b1, job_word_t'(400));
    check("sim at empty holds rd", rd_data, job_word_t'(203));
    check_bit("sim at empty writes", empty, 1'b0);
    step(1'b0, 1'b1, '0);
    check("sim at empty stored", rd_data, job_word_t'(400));

    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < 8; j++) step(1'b1, 1'b0, job_word_t'(1000 + c * 16 + j));
      for (int j = 0; j < 8; j++) begin
        step(1'b0, 1'b1, '0);
        check($sformatf("wrap c%0d j%0d", c, j), rd_data, job_word_t'(1000 + c * 16 + j));
      end
    end

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, job_word_t'(2000 + i));
    #3 rst_n = 1'b1;
    #1;
    check_bit("async reset empty", empty, 1'b1);
    check_bit("async reset full", full, 1'b0);
    check("async reset rd_data", rd_data, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int j = 0; j < 8; j++) step(1'b1, 1'b0, job_word_t'(3000 + j));
    for (int j = 0; j < 8; j++) begin
      step(1'b0, 1'b1, '0);
      check($sformatf("post reset j%0d", j), rd_data, job_word_t'(3000 + j));
    end

    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        pw = $urandom_range(20, 80);
        pr = $urandom_range(20, 80);
      end
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
           {$urandom(), $urandom(), $urandom(), $urandom()});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/job_fifo.md
Name: job_fifo

Overview:
- Synchronous single-clock FIFO that buffers fixed-width job descriptors between a job producer (dispatcher) and a job consumer (execution engine).
- Write side is gated by full; read side is gated by empty.
- Read data is registered, so it appears one cycle after the accepted read.
- Storage depth is a power of two.

Parameters:
- DEPTH, 8, number of entries; must equal 2**ADDR_WIDTH.
- DATA_WIDTH, 128, width of one job descriptor in bits.
- ADDR_WIDTH, 3, index width of the storage array.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous reset, active-high (asserted = 1) despite the codebase name; clears all state immediately.
- wr_en  input  1  write request; accepted on a rising edge when full=0.
- wr_data  input  DATA_WIDTH  job word written on an accepted write.
- full  output  1  high when DEPTH entries are stored.
- rd_en  input  1  read request; accepted on a rising edge when empty=0.
- rd_data  output  DATA_WIDTH  registered data of the most recently accepted read.
- empty  output  1  high when zero entries are stored.

Behaviour:
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide; the low ADDR_WIDTH bits index storage and the MSB is a wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
  - Both flags are combinational from registered pointers, so there are no flag glitches relative to the clock.
- Reset (rst_n=1, asynchronous): wr_ptr=0, rd_ptr=0, rd_data=0, empty=1, full=0. Storage contents are not reset. A reset mid-operation discards all entries.
- Accepted write (wr_en & ~full): mem[wr_ptr] <= wr_data; wr_ptr increments. full reflects the new count in the next cycle.
- Accepted read (rd_en & ~empty): rd_data <= mem[rd_ptr]; rd_ptr increments. Data is valid one cycle after the read edge.
- Dropped requests:
  - Write when full is dropped silently; storage and pointers are unchanged.
  - Read when empty is dropped; rd_data holds its previous value and pointers are unchanged.
- Simultaneous write and read:
  - Both are evaluated against the pre-edge flags.
  - When full: the read is accepted and the write is rejected.
  - When empty: the write is accepted and the read is rejected (no fall-through).
  - Otherwise both are accepted and occupancy is unchanged.
- Ordering is strict FIFO. Pointer wrap-around is transparent across any number of fill/drain cycles.
- rd_data only changes on an accepted read.

Optional Feature:
- Macro JOB_FIFO_COUNT_EN.
- Defined: adds output port count [ADDR_WIDTH:0] equal to wr_ptr - rd_ptr (0..DEPTH), combinational from registered pointers, 0 on reset.
- Also defined: adds sticky 1-bit outputs overflow and underflow, set on a rejected write or rejected read respectively and cleared only by reset.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package job_fifo_pkg holds:
  - default constants JOB_FIFO_DEPTH=8, JOB_FIFO_DATA_WIDTH=128, JOB_FIFO_ADDR_WIDTH=3;
  - a typedef for the job word, logic [JOB_FIFO_DATA_WIDTH-1:0].
- One sub-module, job_fifo_mem: simple dual-port register array with one write port and one registered read port, no reset.
- job_fifo wraps job_fifo_mem and owns the pointers, flags and optional counters.

Test Plan:
- Reset: hold rst_n=1 for 2 cycles -> empty=1, full=0, rd_data=0; with the macro defined, count=0.
- Fill: write 0..7 on 8 consecutive edges -> full=1 and empty=0 after the 8th edge; with the macro defined, count=8.
- Drain: from full, one read per cycle -> rd_data sequence 0,1,...,7, each valid one cycle after its read edge; empty=1 after the 8th read; full=0 after the first read.
- Overflow/underflow:
  - A 9th write of 0xDEAD when full is ignored; later reads still return 0..7. With the macro defined, overflow=1.
  - A read on empty leaves rd_data=7 and the pointers unchanged. With the macro defined, underflow=1.
- Simultaneous: with 4 entries stored, assert wr_en and rd_en together for 10 cycles writing 100..109 -> occupancy stays 4 and reads return the earlier data then 100..105 in order; at full a simultaneous request writes nothing; at empty it reads nothing.
- Wrap and reset: 3 fill/drain cycles of 8 distinct values each, all returned in order; then assert rst_n mid-fill (3 stored) -> empty=1 immediately without a clock edge, and a subsequent fill/drain is correct.
